// File: rtl/ex_pkg.sv
// Shared opcodes, forwarding selects and FSM encoding for the execute stage.
// EX_STAGE_MC_DIV_EN turns on the DIVU/REMU opcodes.
package ex_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SEQ  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Divides share the StMul state.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } ex_state_e;

`ifdef EX_STAGE_MC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (DivEn && ((op == OP_DIVU) || (op == OP_REMU)));
  endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// Iterative shift-add multiplier; restoring divider added under EX_STAGE_MC_DIV_EN.
// One bit per cycle, Width iterations, done pulses during the final iteration.
module ex_muldiv_seq #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             is_div_i,
  input  logic             rem_sel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] res_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [Width-1:0] acc_q, acc_d;
  logic [Width-1:0] opa_q, opa_d;
  logic [Width-1:0] opb_q, opb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             last;
  logic [Width-1:0] mul_acc;

  assign last    = (cnt_q == CntW'(Width - 1));
  assign mul_acc = opb_q[0] ? (acc_q + opa_q) : acc_q;

`ifdef EX_STAGE_MC_DIV_EN
  logic             div_q, div_d;
  logic             rem_q, rem_d;
  logic [Width:0]   rem_shift;
  logic [Width:0]   diff;
  logic [Width-1:0] div_acc;
  logic [Width-1:0] div_quo;

  // opa holds the dividend shifting out / quotient shifting in; acc is the partial remainder.
  always_comb begin
    rem_shift = {acc_q, opa_q[Width-1]};
    diff      = rem_shift - {1'b0, opb_q};
    if (!diff[Width]) begin
      div_acc = diff[Width-1:0];
      div_quo = {opa_q[Width-2:0], 1'b1};
    end else begin
      div_acc = rem_shift[Width-1:0];
      div_quo = {opa_q[Width-2:0], 1'b0};
    end
  end

  always_comb begin
    div_d = div_q;
    rem_d = rem_q;
    if (start_i && !abort_i) begin
      div_d = is_div_i;
      rem_d = rem_sel_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= 1'b0;
      rem_q <= 1'b0;
    end else begin
      div_q <= div_d;
      rem_q <= rem_d;
    end
  end

  assign res_o = (div_q && !rem_q) ? opa_q : acc_q;
`else
  logic unused_div_sel;
  assign unused_div_sel = is_div_i ^ rem_sel_i;
  assign res_o          = acc_q;
`endif

  always_comb begin
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      acc_d  = '0;
      opa_d  = a_i;
      opb_d  = b_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (last) begin
        busy_d = 1'b0;
      end
`ifdef EX_STAGE_MC_DIV_EN
      if (div_q) begin
        acc_d = div_acc;
        opa_d = div_quo;
      end else
`endif
      begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && last;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: forwarding mux, single-cycle ALU, multi-cycle mul/div FSM, EX/MEM register.
// Define EX_STAGE_MC_DIV_EN to enable DIVU/REMU.
module ex_stage_mc
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned RADDR_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [3:0]         op_i,
  input  logic [1:0]         fwd_a_i,
  input  logic [1:0]         fwd_b_i,
  input  logic [WIDTH-1:0]   rs_data_i,
  input  logic [WIDTH-1:0]   rt_data_i,
  input  logic [WIDTH-1:0]   imm_i,
  input  logic               use_imm_i,
  input  logic [RADDR_W-1:0] dest_i,
  input  logic [WIDTH-1:0]   mem_fwd_data_i,
  input  logic [WIDTH-1:0]   wb_fwd_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   result_o,
  output logic [WIDTH-1:0]   store_data_o,
  output logic [RADDR_W-1:0] dest_o,
  output logic               err_o
);

  localparam int unsigned ShW = $clog2(WIDTH);

  ex_state_e state_q, state_d;

  logic [WIDTH-1:0]   opa, opb_fwd, opb;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;
  logic [ShW-1:0]     sh;
  logic [31:0]        sh_inv;
  logic               accept, multi;
  logic               md_busy, md_done;
  logic [WIDTH-1:0]   md_res;

  logic               out_valid_q, out_valid_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   store_q, store_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0]   pend_store_q, pend_store_d;
  logic [RADDR_W-1:0] pend_dest_q, pend_dest_d;

  always_comb begin
    unique case (fwd_a_i)
      FWD_MEM: opa = mem_fwd_data_i;
      FWD_WB:  opa = wb_fwd_data_i;
      default: opa = rs_data_i;
    endcase
    unique case (fwd_b_i)
      FWD_MEM: opb_fwd = mem_fwd_data_i;
      FWD_WB:  opb_fwd = wb_fwd_data_i;
      default: opb_fwd = rt_data_i;
    endcase
    opb = use_imm_i ? imm_i : opb_fwd;
  end

  assign in_ready_o = (state_q == StIdle) && !md_busy && (!out_valid_q || out_ready_i) &&
                      !flush_i;
  assign accept     = in_valid_i && in_ready_o;
  assign multi      = is_multicycle(op_i);

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    sh      = opb[ShW-1:0];
    sh_inv  = 32'(WIDTH) - 32'(sh);
    case (op_i)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_SLL:  alu_res = opa << sh;
      OP_SRL:  alu_res = opa >> sh;
      OP_ROL:  alu_res = (opa << sh) | (opa >> sh_inv);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SEQ:  alu_res = {{(WIDTH-1){1'b0}}, (opa == opb)};
      // MUL/DIV never reach here when enabled; disabled or undefined ops flag an error.
      default: alu_err = 1'b1;
    endcase
  end

  ex_muldiv_seq #(
    .Width(WIDTH)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (accept && multi),
    .abort_i  (flush_i),
    .a_i      (opa),
    .b_i      (opb),
    .is_div_i ((op_i == OP_DIVU) || (op_i == OP_REMU)),
    .rem_sel_i(op_i == OP_REMU),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .res_o    (md_res)
  );

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (accept && multi) state_d = StMul;
        StMul:   if (md_done) state_d = StDone;
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    err_d        = err_q;
    result_d     = result_q;
    store_d      = store_q;
    dest_d       = dest_q;
    pend_store_d = pend_store_q;
    pend_dest_d  = pend_dest_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end else if (accept) begin
      if (multi) begin
        // Any held result was consumed this edge; the new one arrives from StDone.
        out_valid_d  = 1'b0;
        err_d        = 1'b0;
        pend_store_d = opb_fwd;
        pend_dest_d  = dest_i;
      end else begin
        out_valid_d = 1'b1;
        err_d       = alu_err;
        result_d    = alu_res;
        store_d     = opb_fwd;
        dest_d      = dest_i;
      end
    end else if (state_q == StDone) begin
      out_valid_d = 1'b1;
      err_d       = 1'b0;
      result_d    = md_res;
      store_d     = pend_store_q;
      dest_d      = pend_dest_q;
    end else if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= '0;
      store_q      <= '0;
      dest_q       <= '0;
      pend_store_q <= '0;
      pend_dest_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      err_q        <= err_d;
      result_q     <= result_d;
      store_q      <= store_d;
      dest_q       <= dest_d;
      pend_store_q <= pend_store_d;
      pend_dest_q  <= pend_dest_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign err_o        = err_q;
  assign result_o     = result_q;
  assign store_data_o = store_q;
  assign dest_o       = dest_q;

endmodule
